fdc_meas_ctrl: RTL and testbench
================================

FDC_MEAS_CTRL -- requirements
Module: fdc_meas_ctrl

Interface
REQ-001 Parameter RST_CYC, default 4: clk cycles fdc_reset is held high before each window (range 1..15).
REQ-002 Parameter AVG_LOG2, default 2: log2 of windows averaged per result (range 0..3).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a measurement run.
REQ-006 cont  in  1  continuous mode: re-arm after each result until cont is low.
REQ-007 mode  in  1  measurement mode, forwarded to fdc_selec.
REQ-008 win_len  in  8  reference edges per window; 0 means 256.
REQ-009 clk_ref  in  1  reference clock, asynchronous to clk.
REQ-010 fdc_out  in  5  FDC core count output.
REQ-011 fdc_reset  out  1  active-high reset to the FDC core.
REQ-012 fdc_selec  out  1  mode select to the FDC core.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 res_data  out  5  averaged result.
REQ-015 res_valid  out  1  res_data valid; held until accepted.
REQ-016 res_ready  in  1  consumer accepts when res_valid and res_ready are high on the same edge.
REQ-017 overrun  out  1  sticky: a result was dropped.

Function
REQ-018 clk_ref passes a 2-FF synchronizer plus an edge register; a rising edge is detected 3 clk cycles after it occurs.
REQ-019 FSM states: IDLE, ARM, MEAS, SAMPLE, DONE.
REQ-020 IDLE: start=1 latches mode and win_len, clears the accumulator and sample counter, and enters ARM on the next edge.
REQ-021 ARM: fdc_reset=1 for exactly RST_CYC cycles, then MEAS; fdc_reset=0 in every other state.
REQ-022 MEAS: count detected ref edges; on the edge-count reaching the latched win_len, enter SAMPLE.
REQ-023 SAMPLE (one cycle): add fdc_out to the 8-bit accumulator and increment the sample counter; if the count reaches 2^AVG_LOG2 go to DONE, else to ARM.
REQ-024 DONE (one cycle): result = accumulator >> AVG_LOG2, truncated to 5 bits; then go to ARM if cont=1 (accumulator and counter cleared), else to IDLE.
REQ-025 Output register: in DONE, if res_valid=0 or res_ready=1 on that edge, load res_data and set res_valid; otherwise keep the old result and set overrun.
REQ-026 res_valid clears on handshake unless a new result loads on the same edge.
REQ-027 start is ignored while busy=1; a start pulse in IDLE also clears overrun.
REQ-028 fdc_selec tracks the latched mode, which only changes on an accepted start.
REQ-029 Dropping cont mid-run finishes the current result, then returns to IDLE.

Reset
REQ-030 On reset: state IDLE, fdc_reset=1, fdc_selec=0, busy=0, res_data=0, res_valid=0, overrun=0, and all counters, accumulator and synchronizer flops cleared.
REQ-031 Reset mid-run aborts without emitting a result; fdc_reset returns to 0 on the first cycle after reset deasserts.

Configuration
REQ-032 Macro FDC_AVG_EN defined: averaging per REQ-023/024.
REQ-033 Macro FDC_AVG_EN undefined: AVG_LOG2 is ignored; each SAMPLE goes directly to DONE with res_data = fdc_out, and no accumulator is built.

Structure
REQ-034 A shared package fdc_pkg holds the FSM state enum, the 5-bit result width constant and the accumulator width constant.
REQ-035 The synchronizer and edge detector form a sub-module, fdc_ref_edge.

Verification
REQ-036 win_len=4, AVG_LOG2=2, fdc_out=20, start -> fdc_reset high 4 cycles each window; one res_valid with res_data=20; busy low afterwards.
REQ-037 AVG_LOG2=2, fdc_out 10/11/12/13 across windows -> res_data=11.
REQ-038 cont=1, res_ready=0, two results -> first result kept, overrun=1; start in IDLE after cont=0 -> overrun=0.
REQ-039 win_len=0 -> exactly 256 detected ref edges per window before SAMPLE.
REQ-040 reset asserted in MEAS -> next cycle all outputs at reset values, no res_valid; start during a run -> ignored.
REQ-041 FDC_AVG_EN undefined, fdc_out=7 -> res_valid after one window with res_data=7.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared types and widths for the FDC measurement controller.
package fdc_pkg;

   localparam int RES_W = 5;
   localparam int ACC_W = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARM    = 3'd1;
   localparam logic [2:0] ST_MEAS   = 3'd2;
   localparam logic [2:0] ST_SAMPLE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      ARM    = ST_ARM,
      MEAS   = ST_MEAS,
      SAMPLE = ST_SAMPLE,
      DONE   = ST_DONE
   } fdc_state_e;

   // A window length of zero encodes the full 256 reference edges.
   function automatic logic [8:0] win_target(input logic [7:0] wl);
      return (wl == 8'd0) ? 9'd256 : {1'b0, wl};
   endfunction

endpackage

// File: rtl/fdc_meas_ctrl_if.sv
// Result handshake between the measurement controller and its consumer.
interface fdc_meas_ctrl_if;
   import fdc_pkg::*;

   logic [RES_W-1:0] res_data;
   logic             res_valid;
   logic             res_ready;

   modport master (output res_data, output res_valid, input res_ready);
   modport slave  (input res_data, input res_valid, output res_ready);

endinterface

// File: rtl/fdc_ref_edge.sv
// Brings clk_ref into the clk domain and flags its rising edges; a rising edge
// is acted on at the third clk edge after it occurs.
module fdc_ref_edge (
   input  logic clk,
   input  logic reset,
   input  logic clk_ref,
   output logic ref_rise
);

   // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
   logic [2:0] sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= 3'b000;
      end else begin
         sync <= {sync[1:0], clk_ref};
      end
   end

   assign ref_rise = sync[1] & ~sync[2];

endmodule

// File: rtl/fdc_meas_ctrl.sv
// FDC measurement sequencer: reset the core, count reference edges, sample and
// optionally average (macro FDC_AVG_EN) before handing a held result downstream.
module fdc_meas_ctrl
   import fdc_pkg::*;
#(
   parameter int RST_CYC  = 4,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cont,
   input  logic              mode,
   input  logic [7:0]        win_len,
   input  logic              clk_ref,
   input  logic [RES_W-1:0]  fdc_out,
   output logic              fdc_reset,
   output logic              fdc_selec,
   output logic              busy,
   output logic              overrun,
   fdc_meas_ctrl_if.master   res
);

   if (RST_CYC < 1 || RST_CYC > 15 || AVG_LOG2 < 0 || AVG_LOG2 > 3) begin : g_param_chk
      $error("fdc_meas_ctrl: RST_CYC or AVG_LOG2 out of range");
   end

   localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

   fdc_state_e       state;
   fdc_state_e       state_nxt;
   logic             mode_q;
   logic [7:0]       win_q;
   logic [3:0]       rst_cnt;
   logic [8:0]       edge_cnt;
   logic             ref_rise;
   logic [RES_W-1:0] result;
   logic [RES_W-1:0] res_data_q;
   logic             res_valid_q;
   logic             accept_start;
   logic             load_res;

`ifdef FDC_AVG_EN
   localparam logic [3:0] AVG_N = 4'(1 << AVG_LOG2);
   logic [ACC_W-1:0] acc;
   logic [3:0]       smp_cnt;
`else
   logic [RES_W-1:0] smp_data;
`endif

   fdc_ref_edge u_ref_edge (
      .clk      (clk),
      .reset    (reset),
      .clk_ref  (clk_ref),
      .ref_rise (ref_rise)
   );

   assign accept_start = (state == IDLE) && start;
   assign load_res     = (state == DONE) && (!res_valid_q || res.res_ready);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ARM;
         ARM:     if (rst_cnt == RST_LAST) state_nxt = MEAS;
         MEAS:    if (ref_rise && ((edge_cnt + 9'd1) == win_target(win_q))) state_nxt = SAMPLE;
`ifdef FDC_AVG_EN
         SAMPLE:  state_nxt = ((smp_cnt + 4'd1) == AVG_N) ? DONE : ARM;
`else
         SAMPLE:  state_nxt = DONE;
`endif
         DONE:    state_nxt = cont ? ARM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         fdc_reset <= 1'b1;
         mode_q    <= 1'b0;
         win_q     <= 8'd0;
         rst_cnt   <= 4'd0;
         edge_cnt  <= 9'd0;
      end else begin
         state     <= state_nxt;
         // Registered from the next state so the pulse spans exactly the ARM cycles.
         fdc_reset <= (state_nxt == ARM);
         rst_cnt   <= (state == ARM) ? rst_cnt + 4'd1 : 4'd0;
         edge_cnt  <= (state == MEAS) ? edge_cnt + {8'd0, ref_rise} : 9'd0;
         if (accept_start) begin
            mode_q <= mode;
            win_q  <= win_len;
         end
      end
   end

`ifdef FDC_AVG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         smp_cnt <= 4'd0;
      end else if (accept_start || state == DONE) begin
         acc     <= '0;
         smp_cnt <= 4'd0;
      end else if (state == SAMPLE) begin
         acc     <= acc + ACC_W'(fdc_out);
         smp_cnt <= smp_cnt + 4'd1;
      end
   end

   assign result = RES_W'(acc >> AVG_LOG2);
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         smp_data <= '0;
      end else if (state == SAMPLE) begin
         smp_data <= fdc_out;
      end
   end

   assign result = smp_data;
`endif

   // A result that cannot be handed over is dropped; the held one stays intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (load_res) begin
            res_data_q  <= result;
            res_valid_q <= 1'b1;
         end else if (res_valid_q && res.res_ready) begin
            res_valid_q <= 1'b0;
         end
         if (state == DONE && !load_res) begin
            overrun <= 1'b1;
         end else if (accept_start) begin
            overrun <= 1'b0;
         end
      end
   end

   assign res.res_data  = res_data_q;
   assign res.res_valid = res_valid_q;
   assign busy          = (state != IDLE);
   assign fdc_selec     = mode_q;

endmodule

// File: tb/tb_fdc_meas_ctrl.sv
// Scoreboard bench for fdc_meas_ctrl; expectations follow FDC_AVG_EN.
`timescale 1ns/1ps
module tb_fdc_meas_ctrl;
   import fdc_pkg::*;

   localparam int RST_CYC  = 4;
   localparam int AVG_LOG2 = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             cont;
   logic             mode;
   logic [7:0]       win_len;
   logic             clk_ref;
   logic [RES_W-1:0] fdc_out;
   logic             fdc_reset;
   logic             fdc_selec;
   logic             busy;
   logic             overrun;

   fdc_meas_ctrl_if res ();

   fdc_meas_ctrl #(.RST_CYC(RST_CYC), .AVG_LOG2(AVG_LOG2)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cont      (cont),
      .mode      (mode),
      .win_len   (win_len),
      .clk_ref   (clk_ref),
      .fdc_out   (fdc_out),
      .fdc_reset (fdc_reset),
      .fdc_selec (fdc_selec),
      .busy      (busy),
      .overrun   (overrun),
      .res       (res)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [RES_W-1:0] exp_q[$];
   int               arm_runs = 0;
   bit               ref_free = 1'b1;
   int               ref_target = 0;
   int               ref_sent = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         0:       return busy;
         1:       return fdc_reset;
         2:       return overrun;
         default: return res.res_valid;
      endcase
   endfunction

   task automatic wait_for(input int sel, input logic val, input int max_cyc, input string nm);
      int n = 0;
      forever begin
         @(negedge clk);
         if (probe(sel) === val) break;
         n++;
         if (n >= max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, wanted %0d", nm, n, val);
            break;
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Reference clock: 6 clk cycles per period, free-running or counted pulses.
   initial begin
      clk_ref = 1'b0;
      forever begin
         @(negedge clk);
         if (ref_free || ref_sent < ref_target) begin
            clk_ref = 1'b1;
            repeat (3) @(negedge clk);
            clk_ref = 1'b0;
            repeat (2) @(negedge clk);
            ref_sent++;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake and times each ARM pulse.
   initial begin
      bit prev_fr = 1'b1;
      bit in_run  = 1'b0;
      int run_len = 0;
      logic [RES_W-1:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_fr = 1'b1;
            in_run  = 1'b0;
         end else begin
            if (fdc_reset && !prev_fr) begin
               in_run  = 1'b1;
               run_len = 0;
            end
            if (fdc_reset && in_run) run_len++;
            if (!fdc_reset && prev_fr && in_run) begin
               chk("arm_len", run_len, RST_CYC);
               arm_runs++;
               in_run = 1'b0;
            end
            prev_fr = fdc_reset;
            if (res.res_valid && res.res_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: got %0d, expected no result", res.res_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_data", res.res_data, e);
               end
            end
         end
      end
   end

   initial begin
      int base_runs;
      reset = 1'b1; start = 1'b0; cont = 1'b0; mode = 1'b0;
      win_len = 8'd4; fdc_out = '0; res.res_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fdc_reset", fdc_reset, 1);
      chk("rst_fdc_selec", fdc_selec, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res.res_valid, 0);
      chk("rst_res_data", res.res_data, 0);
      chk("rst_overrun", overrun, 0);
      step();
      reset = 1'b0;
      step();

      // Basic run, constant sample 20, mode 1.
      fdc_out = 5'd20; mode = 1'b1; win_len = 8'd4; cont = 1'b0;
      exp_q.push_back(5'd20);
      pulse_start();
      wait_for(1, 1'b1, 20, "t1_arm");
      chk("t1_selec", fdc_selec, 1);
      chk("t1_busy", busy, 1);
      wait_for(0, 1'b0, 1000, "t1_idle");
      @(negedge clk);
      chk("t1_valid_clear", res.res_valid, 0);
      chk("t1_busy_after", busy, 0);

      // Varying samples 10..13 per window.
      step();
      mode = 1'b0; cont = 1'b1;
`ifdef FDC_AVG_EN
      exp_q.push_back(5'd11);
`else
      exp_q.push_back(5'd10); exp_q.push_back(5'd11);
      exp_q.push_back(5'd12); exp_q.push_back(5'd13);
`endif
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         wait_for(1, 1'b1, 600, "t2_arm");
         fdc_out = 5'(10 + i);
         if (i == 3) cont = 1'b0;
         wait_for(1, 1'b0, 100, "t2_meas");
      end
      wait_for(0, 1'b0, 1000, "t2_idle");

      // Overrun: consumer stalled across several results.
      step();
      res.res_ready = 1'b0; cont = 1'b1; fdc_out = 5'd6;
      exp_q.push_back(5'd6);
      pulse_start();
      wait_for(3, 1'b1, 1000, "t3_first");
      fdc_out = 5'd25;
      wait_for(2, 1'b1, 1000, "t3_overrun");
      cont = 1'b0;
      wait_for(0, 1'b0, 1000, "t3_idle");
      chk("t3_overrun_held", overrun, 1);
      chk("t3_valid_held", res.res_valid, 1);
      step();
      res.res_ready = 1'b1;
      step();
      @(negedge clk);
      chk("t3_valid_clear", res.res_valid, 0);
      exp_q.push_back(5'd25);
      pulse_start();
      @(negedge clk);
      chk("t3_overrun_cleared", overrun, 0);
      wait_for(0, 1'b0, 1000, "t3_idle2");

      // win_len = 0: exactly 256 detected edges close a window.
      step();
      ref_free = 1'b0;
      repeat (8) step();
      ref_target = ref_sent;
      win_len = 8'd0; fdc_out = 5'd9; cont = 1'b0;
      exp_q.push_back(5'd9);
      pulse_start();
      wait_for(1, 1'b1, 20, "t4_arm");
      wait_for(1, 1'b0, 20, "t4_meas");
      step();
      base_runs  = arm_runs;
      ref_target = ref_sent + 255;
      for (int n = 0; n < 2000 && ref_sent < ref_target; n++) @(negedge clk);
      chk("t4_sent255", ref_sent, ref_target);
      repeat (10) step();
      chk("t4_open_busy", busy, 1);
      chk("t4_open_runs", arm_runs, base_runs);
      ref_target = ref_target + 1;
      for (int n = 0; n < 50 && ref_sent < ref_target; n++) @(negedge clk);
      repeat (10) step();
`ifdef FDC_AVG_EN
      chk("t4_closed_runs", arm_runs, base_runs + 1);
`else
      chk("t4_closed_idle", busy, 0);
`endif
      ref_free = 1'b1;
      wait_for(0, 1'b0, 8000, "t4_idle");

      // Start during a run is ignored.
      step();
      win_len = 8'd4; fdc_out = 5'd5; mode = 1'b0;
      exp_q.push_back(5'd5);
      pulse_start();
      wait_for(1, 1'b1, 20, "t5_arm");
      wait_for(1, 1'b0, 20, "t5_meas");
      mode = 1'b1; win_len = 8'd200;
      pulse_start();
      @(negedge clk);
      chk("t5_selec_kept", fdc_selec, 0);
      wait_for(0, 1'b0, 400, "t5_idle");

      // Reset in MEAS aborts the run.
      step();
      win_len = 8'd4; fdc_out = 5'd17; mode = 1'b1;
      pulse_start();
      wait_for(1, 1'b1, 20, "t6_arm");
      wait_for(1, 1'b0, 20, "t6_meas");
      repeat (3) step();
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("t6_fdc_reset", fdc_reset, 1);
      chk("t6_selec", fdc_selec, 0);
      chk("t6_busy", busy, 0);
      chk("t6_valid", res.res_valid, 0);
      chk("t6_data", res.res_data, 0);
      chk("t6_overrun", overrun, 0);
      step();
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_fdc_reset_low", fdc_reset, 0);
      repeat (100) step();

      // Full-scale sample with a one-edge window.
      win_len = 8'd1; fdc_out = 5'd31; mode = 1'b0;
      exp_q.push_back(5'd31);
      pulse_start();
      wait_for(0, 1'b0, 400, "t7_idle");
      repeat (5) step();

      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
